// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port block-memory arbiter: FSM states, op encoding, default block width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int DEFAULT_BLOCK_WIDTH = 128;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; zero latency, no backpressure.
// On contention the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] active,
  input  logic       last_grant,
  output logic       pick_vld,
  output logic       pick
);

  always_comb begin
    pick_vld = |active;
    pick     = 1'b0;
    if (active == 2'b11) begin
      pick = ~last_grant;
    end else if (active[1]) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory between two cache controllers; 1-cycle grant latency,
// grant held until mem_ready, then a 1-cycle ready pulse. Optional watchdog under ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BLOCK_WIDTH    = DEFAULT_BLOCK_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_read,
  input  logic                   req0_write,
  input  logic [WIDTH-1:0]       req0_addr,
  input  logic [WIDTH-1:0]       req0_wdata,
  output logic                   ready0,
  input  logic                   req1_read,
  input  logic                   req1_write,
  input  logic [WIDTH-1:0]       req1_addr,
  input  logic [WIDTH-1:0]       req1_wdata,
  output logic                   ready1,
  output logic [BLOCK_WIDTH-1:0] rdata_block,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WIDTH-1:0]       mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [BLOCK_WIDTH-1:0] mem_block_rdata,
  input  logic                   mem_ready,
  output logic                   grant,
  output logic                   busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  state_t     state;
  logic       pick_vld;
  logic       pick;
  op_t        sel_op;
  logic [1:0] active;

  assign active = {req1_read | req1_write, req0_read | req0_write};

  rr_arbiter2 u_rr (
    .active     (active),
    .last_grant (grant),
    .pick_vld   (pick_vld),
    .pick       (pick)
  );

  // Read wins when a port raises both strobes.
  assign sel_op = (pick ? req1_read : req0_read) ? OP_READ : OP_WRITE;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      ready0      <= 1'b0;
      ready1      <= 1'b0;
      busy        <= 1'b0;
      grant       <= 1'b1;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_block <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready0 <= 1'b0;
          ready1 <= 1'b0;
          if (pick_vld) begin
            grant     <= pick;
            mem_addr  <= pick ? req1_addr : req0_addr;
            mem_wdata <= pick ? req1_wdata : req0_wdata;
            mem_read  <= (sel_op == OP_READ);
            mem_write <= (sel_op == OP_WRITE);
            busy      <= 1'b1;
            state     <= BUSY;
`ifdef ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (mem_read) begin
              rdata_block <= mem_block_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ready0    <= ~grant;
            ready1    <= grant;
            state     <= DONE;
`ifdef ARB_TIMEOUT_EN
          end else if (wd_expired) begin
            // Release the owner without touching rdata_block.
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            ready0      <= ~grant;
            ready1      <= grant;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          // One dead cycle so the winner can drop its request before re-arbitration.
          ready0 <= 1'b0;
          ready1 <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_read, req0_write, req1_read, req1_write;
  logic [W-1:0]  req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic          ready0, ready1;
  logic [BW-1:0] rdata_block;
  logic          mem_read, mem_write;
  logic [W-1:0]  mem_addr, mem_wdata;
  logic [BW-1:0] mem_block_rdata;
  logic          mem_ready;
  logic          grant, busy;
`ifdef ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam logic [BW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [BW-1:0] PAT_3C = {16{8'h3C}};

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .BLOCK_WIDTH(BW), .TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_read       (req0_read),
    .req0_write      (req0_write),
    .req0_addr       (req0_addr),
    .req0_wdata      (req0_wdata),
    .ready0          (ready0),
    .req1_read       (req1_read),
    .req1_write      (req1_write),
    .req1_addr       (req1_addr),
    .req1_wdata      (req1_wdata),
    .ready1          (ready1),
    .rdata_block     (rdata_block),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_block_rdata (mem_block_rdata),
    .mem_ready       (mem_ready),
    .grant           (grant),
    .busy            (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0_read = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_read = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    mem_ready = 0; mem_block_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  // Acts as the memory: waits (bounded) for a strobe, answers after lat cycles,
  // returns at the negedge where the DONE cycle is visible.
  task automatic serve(input int lat, input logic [BW-1:0] data, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read || mem_write) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok) begin
      repeat (lat) tick();
      mem_block_rdata = data;
      mem_ready = 1;
      tick();
      mem_ready = 0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    req0_read = 1; req0_addr = 32'h1234;
    tick(); tick();
    chk_cnt++; if ({mem_read, mem_write, ready0, ready1, busy} !== 5'b0) $display("FAIL reset_strobes got=%b exp=00000", {mem_read, mem_write, ready0, ready1, busy}); else pass_cnt++;
    chk_cnt++; if (grant !== 1'b1) $display("FAIL reset_grant got=%b exp=1", grant); else pass_cnt++;
    chk_cnt++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_addr_wdata got=%h exp=0", {mem_addr, mem_wdata}); else pass_cnt++;
    chk_cnt++; if (rdata_block !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata_block); else pass_cnt++;
    clear_inputs();
    rst = 1;
    tick();
    // mem_ready while IDLE must be ignored
    mem_ready = 1; mem_block_rdata = PAT_3C;
    tick();
    mem_ready = 0;
    tick();
    chk_cnt++; if ({ready0, ready1, busy} !== 3'b0) $display("FAIL idle_mem_ready got=%b exp=000", {ready0, ready1, busy}); else pass_cnt++;
    chk_cnt++; if (rdata_block !== '0) $display("FAIL idle_rdata got=%h exp=0", rdata_block); else pass_cnt++;
  endtask

  task automatic test_single_read();
    bit ok;
    do_reset();
    req0_read = 1; req0_addr = 32'h40;
    tick();
    chk_cnt++; if ({mem_read, mem_write, busy, grant} !== 4'b1010) $display("FAIL rd_grant got=%b exp=1010", {mem_read, mem_write, busy, grant}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 32'h40) $display("FAIL rd_addr got=%h exp=40", mem_addr); else pass_cnt++;
    serve(3, PAT_A5, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL rd_strobe_timeout got=%b exp=1", ok); else pass_cnt++;
    chk_cnt++; if ({ready0, ready1, mem_read} !== 3'b100) $display("FAIL rd_ready got=%b exp=100", {ready0, ready1, mem_read}); else pass_cnt++;
    chk_cnt++; if (rdata_block !== PAT_A5) $display("FAIL rd_data got=%h exp=%h", rdata_block, PAT_A5); else pass_cnt++;
    req0_read = 0;
    tick();
    chk_cnt++; if ({ready0, ready1, busy} !== 3'b000) $display("FAIL rd_pulse_end got=%b exp=000", {ready0, ready1, busy}); else pass_cnt++;
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    req0_read = 1; req0_addr = 32'h100;
    req1_write = 1; req1_addr = 32'h200; req1_wdata = 32'hDEADBEEF;
    tick();
    chk_cnt++; if ({grant, mem_read, mem_write} !== 3'b010) $display("FAIL cont_first got=%b exp=010", {grant, mem_read, mem_write}); else pass_cnt++;
    serve(2, PAT_A5, ok);
    chk_cnt++; if ({ok, ready0, ready1} !== 3'b110) $display("FAIL cont_ready0 got=%b exp=110", {ok, ready0, ready1}); else pass_cnt++;
    req0_read = 0;
    tick(); tick();
    chk_cnt++; if ({grant, mem_read, mem_write} !== 3'b101) $display("FAIL cont_second got=%b exp=101", {grant, mem_read, mem_write}); else pass_cnt++;
    chk_cnt++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hDEADBEEF}) $display("FAIL cont_wr_req got=%h exp=00000200deadbeef", {mem_addr, mem_wdata}); else pass_cnt++;
    serve(1, PAT_3C, ok);
    chk_cnt++; if ({ok, ready0, ready1} !== 3'b101) $display("FAIL cont_ready1 got=%b exp=101", {ok, ready0, ready1}); else pass_cnt++;
    // a write completion leaves the last read block in place
    chk_cnt++; if (rdata_block !== PAT_A5) $display("FAIL cont_wr_rdata got=%h exp=%h", rdata_block, PAT_A5); else pass_cnt++;
    req1_write = 0;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    logic exp_g;
    do_reset();
    req0_read = 1; req0_addr = 32'h10;
    req1_read = 1; req1_write = 1; req1_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 1);
      serve(1, PAT_3C, ok);
      chk_cnt++; if ({ok, grant, ready1, ready0} !== {1'b1, exp_g, exp_g, ~exp_g}) $display("FAIL rr_txn%0d got=%b exp=%b", i, {ok, grant, ready1, ready0}, {1'b1, exp_g, exp_g, ~exp_g}); else pass_cnt++;
      tick();
      chk_cnt++; if ({ready0, ready1} !== 2'b00) $display("FAIL rr_pulse%0d got=%b exp=00", i, {ready0, ready1}); else pass_cnt++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold_stable();
    bit ok;
    do_reset();
    req0_read = 1; req0_addr = 32'h40;
    tick();
    req0_addr = 32'h80; req0_read = 0; req0_write = 1; req0_wdata = 32'h55;
    tick(); tick();
    chk_cnt++; if ({mem_addr, mem_read, mem_write} !== {32'h40, 2'b10}) $display("FAIL hold_req got=%h exp=%h", {mem_addr, mem_read, mem_write}, {32'h40, 2'b10}); else pass_cnt++;
    serve(1, PAT_A5, ok);
    chk_cnt++; if ({ok, mem_addr} !== {1'b1, 32'h40}) $display("FAIL hold_done got=%h exp=%h", {ok, mem_addr}, {1'b1, 32'h40}); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req0_read = 1; req0_addr = 32'h44;
    tick(); tick();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy); else pass_cnt++;
    rst = 0;
    tick();
    chk_cnt++; if ({mem_read, busy, ready0, ready1, grant} !== 5'b00001) $display("FAIL mid_reset got=%b exp=00001", {mem_read, busy, ready0, ready1, grant}); else pass_cnt++;
    rst = 1; req0_read = 0;
    req1_write = 1; req1_addr = 32'h88; req1_wdata = 32'h77;
    tick();
    chk_cnt++; if ({grant, mem_write, mem_addr} !== {2'b11, 32'h88}) $display("FAIL mid_regrant got=%h exp=%h", {grant, mem_write, mem_addr}, {2'b11, 32'h88}); else pass_cnt++;
    clear_inputs();
    do_reset();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_reset got=%b exp=0", timeout_err); else pass_cnt++;
    req0_read = 1; req0_addr = 32'h40;
    tick();
    repeat (7) tick();
    chk_cnt++; if ({ready0, busy, timeout_err} !== 3'b010) $display("FAIL to_early got=%b exp=010", {ready0, busy, timeout_err}); else pass_cnt++;
    tick();
    chk_cnt++; if ({ready0, ready1, timeout_err, mem_read} !== 4'b1010) $display("FAIL to_fire got=%b exp=1010", {ready0, ready1, timeout_err, mem_read}); else pass_cnt++;
    chk_cnt++; if (rdata_block !== '0) $display("FAIL to_rdata got=%h exp=0", rdata_block); else pass_cnt++;
    req0_read = 0;
    tick(); tick();
    chk_cnt++; if ({ready0, timeout_err} !== 2'b01) $display("FAIL to_sticky got=%b exp=01", {ready0, timeout_err}); else pass_cnt++;
    do_reset();
    tick();
    chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_clear got=%b exp=0", timeout_err); else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 0;
    clear_inputs();
    tick();
    test_reset();
    test_single_read();
    test_contention();
    test_round_robin();
    test_hold_stable();
    test_reset_midflight();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter sharing the single 128-bit block memory between requester 0 (data cache controller) and requester 1 (instruction-side or second cache controller).
It accepts read/write requests, grants one at a time using round-robin priority, and forwards the request to memory.
It holds the grant until the memory signals ready, then routes the 128-bit block and a one-cycle ready pulse back to the winner.
It sits between the cache controllers and the block memory.

Parameters:
WIDTH, 32, address and write-data width
BLOCK_WIDTH, 128, memory block width returned on reads
TIMEOUT_CYCLES, 64, watchdog limit; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (reset when rst==0 at clk edge)
req0_read  input  1  requester 0 block read request, level, held until ready0
req0_write  input  1  requester 0 word write request, level, held until ready0
req0_addr  input  WIDTH  requester 0 address
req0_wdata  input  WIDTH  requester 0 write data
ready0  output  1  one-cycle completion pulse to requester 0
req1_read, req1_write, req1_addr, req1_wdata, ready1  as above for requester 1
rdata_block  output  BLOCK_WIDTH  registered block from last completed read; valid when ready0/ready1 pulses
mem_read  output  1  read strobe to memory, level during granted read
mem_write  output  1  write strobe to memory, level during granted write
mem_addr  output  WIDTH  granted address, registered at grant
mem_wdata  output  WIDTH  granted write data, registered at grant
mem_block_rdata  input  BLOCK_WIDTH  block from memory
mem_ready  input  1  memory completion pulse
grant  output  1  current/last owner (0 or 1)
busy  output  1  high while a transaction is outstanding

Behaviour:
- Reset (rst==0): state IDLE.
  - mem_read, mem_write, ready0, ready1, busy = 0.
  - grant = 1, so requester 0 wins the first contention.
  - mem_addr, mem_wdata, rdata_block = 0.
  - Reset mid-transaction drops the transaction silently with no ready pulse.
- A requester is active if read|write is asserted. Read and write both high on one port: read wins, write ignored.
- Arbitration happens in IDLE only:
  - One requester active: grant to it.
  - Both active: grant to the port not equal to the last grant (round-robin).
- IDLE -> BUSY on grant, at the clock edge:
  - Latch addr and wdata into mem_addr and mem_wdata.
  - Latch op into mem_read or mem_write.
  - Update grant; busy = 1.
  - Memory sees the request the cycle after the requester asserts (1-cycle grant latency).
- BUSY: the latched request is held stable. Requester input changes are ignored until completion.
- BUSY -> DONE when mem_ready==1:
  - Deassert mem_read and mem_write.
  - Capture mem_block_rdata into rdata_block (reads only; writes leave it unchanged).
  - Pulse ready<grant> for exactly one cycle (in DONE).
- DONE -> IDLE unconditionally, busy = 0.
  - The DONE cycle prevents re-granting a requester that has not yet dropped its request in response to ready.
  - Arbitration resumes in IDLE the following cycle, so minimum spacing between grants is 3 cycles.
- mem_ready while IDLE or DONE is ignored.
- No starvation: with both ports continuously requesting, grants strictly alternate 0,1,0,1.

Optional Feature:
ARB_TIMEOUT_EN:
- When defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without mem_ready, go to DONE, pulse the owner's ready, and set sticky output timeout_err=1 (cleared only by reset).
  - rdata_block is not updated on a timeout.
- When undefined: no counter and no timeout_err port; BUSY waits indefinitely for mem_ready.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY, DONE), op encoding (OP_READ, OP_WRITE), default BLOCK_WIDTH constant.
- One natural sub-module: rr_arbiter2, a combinational two-way round-robin pick from active bits plus last grant. The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Reset then req0_read=1, addr=0x40; memory returns 0xA5..A5 with mem_ready 3 cycles after mem_read -> mem_addr=0x40 one cycle after request; ready0 pulses one cycle; rdata_block=0xA5..A5; ready1 stays 0.
- req0_read and req1_write asserted together from reset -> grant=0 first; after ready0, requester 1 granted with mem_write=1, mem_wdata=req1_wdata.
- Both ports hold requests for 6 transactions -> grant order 0,1,0,1,0,1; each ready pulse lasts exactly 1 cycle.
- During BUSY, change req0_addr from 0x40 to 0x80 -> mem_addr remains 0x40 until completion.
- Drive rst=0 while BUSY -> next cycle mem_read=0, busy=0, no ready pulse; the next request is arbitrated normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted -> ready0 pulses after 8 BUSY cycles, timeout_err=1 and stays 1 until reset.
